slave_arbitrate_interface_ddr2fifo: RTL and testbench

//  Read-side arbiter slave: pulls one frame from DDR in fixed bursts into a downstream tx FIFO (eth path).

---
 rtl/slave_arbitrate_interface_ddr2fifo_pkg.sv | 23 ++
 rtl/slave_arbitrate_interface_ddr2fifo.sv | 118 +++++++++++
 tb/tb_slave_arbitrate_interface_ddr2fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/slave_arbitrate_interface_ddr2fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slave_arbitrate_interface_ddr2fifo_pkg                           |
// | Shared slave FSM encoding and DDR slave address field widths.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package slave_arbitrate_interface_ddr2fifo_pkg;

  localparam int unsigned C_BANK_W  = 2;
  localparam int unsigned C_PARAM_W = 1;
  localparam int unsigned C_SLAVE_W = 4;
  localparam int unsigned C_ADDR_W  = 18;
  localparam int unsigned C_RADDR_W = C_BANK_W + C_PARAM_W + C_SLAVE_W + C_ADDR_W;

  typedef logic [1:0] slave_state_t;

  localparam slave_state_t C_ST_IDLE  = 2'd0;
  localparam slave_state_t C_ST_FILL  = 2'd1;
  localparam slave_state_t C_ST_REQ   = 2'd2;
  localparam slave_state_t C_ST_BURST = 2'd3;

endpackage
`default_nettype wire

// File: rtl/slave_arbitrate_interface_ddr2fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slave_arbitrate_interface_ddr2fifo                               |
// | Read-side arbiter slave: streams one DDR frame into the tx FIFO. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module slave_arbitrate_interface_ddr2fifo
  import slave_arbitrate_interface_ddr2fifo_pkg::*;
#(
  parameter logic [3:0]  SLAVE_NUMBER = 4'b0000,
  parameter logic        PARAM_BIT    = 1'b0,
  parameter logic [17:0] MAXADDR      = 18'd245_760,
  parameter logic [9:0]  BURST_LEN    = 10'd256,
  parameter logic [10:0] FIFO_DEPTH   = 11'd1024
) (
  input  logic                 ddr_clk,
  input  logic                 sys_rstn,
  input  logic                 frame_start,
  input  logic [C_BANK_W-1:0]  slave_wrbank,
  input  logic [10:0]          fifo_wr_len,
  input  logic                 fifo_full_flag,
  output logic                 slave_req,
  input  logic                 arbitrate_valid,
  output logic [C_RADDR_W-1:0] slave_raddr,
  output logic [9:0]           slave_rburst_len,
  output logic                 slave_frame_finished,
  output logic                 frame_overrun_error,
  output logic                 fifo_overflow_error
);

  localparam logic [10:0] C_FILL_LIMIT = FIFO_DEPTH - 11'(BURST_LEN);

  slave_state_t          r_state;
  slave_state_t          w_state_nxt;
  logic                  r_valid_d;
  logic                  r_req;
  logic [C_BANK_W-1:0]   r_rdbank;
  logic [C_ADDR_W-1:0]   r_addr;
  logic [9:0]            r_burst_len;
  logic                  r_finished;
  logic                  r_overrun;
  logic                  r_overflow;

  logic                  w_valid_fall;
  logic [C_ADDR_W-1:0]   w_addr_sum;
  logic                  w_frame_load;
  logic                  w_advance;
  logic                  w_frame_done;
  logic                  w_overrun_nxt;
  logic                  w_overflow_nxt;

  assign w_valid_fall = r_valid_d & ~arbitrate_valid;
  assign w_addr_sum   = r_addr + C_ADDR_W'(BURST_LEN);

  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= C_ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE:  if (frame_start) w_state_nxt = C_ST_FILL;
      C_ST_FILL:  if (fifo_wr_len <= C_FILL_LIMIT) w_state_nxt = C_ST_REQ;
      C_ST_REQ:   if (arbitrate_valid) w_state_nxt = C_ST_BURST;
      C_ST_BURST: if (w_valid_fall)
                    w_state_nxt = (w_addr_sum == MAXADDR) ? C_ST_IDLE : C_ST_FILL;
      default:    w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_comb begin
    w_frame_load   = (r_state == C_ST_IDLE) && frame_start;
    w_advance      = (r_state == C_ST_BURST) && w_valid_fall;
    w_frame_done   = w_advance && (w_addr_sum == MAXADDR);
    w_overrun_nxt  = (r_state != C_ST_IDLE) && frame_start;
    w_overflow_nxt = (r_state == C_ST_BURST) && fifo_full_flag;
  end

  // Bank and address only move on frame load or completed burst; request tracks REQ state.
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_valid_d   <= 1'b0;
      r_req       <= 1'b0;
      r_rdbank    <= '0;
      r_addr      <= '0;
      r_burst_len <= '0;
      r_finished  <= 1'b0;
      r_overrun   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid_d   <= arbitrate_valid;
      r_req       <= (w_state_nxt == C_ST_REQ);
      r_burst_len <= BURST_LEN;
      r_overrun   <= w_overrun_nxt;
      r_overflow  <= w_overflow_nxt;
      if (w_frame_load) begin
        r_rdbank   <= slave_wrbank - 2'd1;
        r_addr     <= '0;
        r_finished <= 1'b0;
      end else if (w_frame_done) begin
        r_addr     <= '0;
        r_finished <= 1'b1;
      end else if (w_advance) begin
        r_addr     <= w_addr_sum;
      end
    end
  end

  assign slave_req            = r_req;
  assign slave_raddr          = {r_rdbank, PARAM_BIT, SLAVE_NUMBER, r_addr};
  assign slave_rburst_len     = r_burst_len;
  assign slave_frame_finished = r_finished;
  assign frame_overrun_error  = r_overrun;
  assign fifo_overflow_error  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_slave_arbitrate_interface_ddr2fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_slave_arbitrate_interface_ddr2fifo                            |
// | Directed self-checking bench for the DDR-to-FIFO read slave.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_slave_arbitrate_interface_ddr2fifo;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [1:0]  wrbank;
  logic [10:0] fifo_wr_len;
  logic        fifo_full;
  logic        valid;
  logic        req;
  logic [24:0] raddr;
  logic [9:0]  blen;
  logic        finished;
  logic        overrun;
  logic        overflow;

  int n_vec;
  int n_err;

  slave_arbitrate_interface_ddr2fifo dut (
    .ddr_clk              (clk),
    .sys_rstn             (rst_n),
    .frame_start          (frame_start),
    .slave_wrbank         (wrbank),
    .fifo_wr_len          (fifo_wr_len),
    .fifo_full_flag       (fifo_full),
    .slave_req            (req),
    .arbitrate_valid      (valid),
    .slave_raddr          (raddr),
    .slave_rburst_len     (blen),
    .slave_frame_finished (finished),
    .frame_overrun_error  (overrun),
    .fifo_overflow_error  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    wrbank = 2'b00;
    fifo_wr_len = 11'd0;
    fifo_full = 1'b0;
    valid = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req", 25'(req), 25'd0);
    chk("rst_raddr", raddr, 25'd0);
    chk("rst_blen", 25'(blen), 25'd0);
    chk("rst_finished", 25'(finished), 25'd0);
    chk("rst_overrun", 25'(overrun), 25'd0);
    chk("rst_overflow", 25'(overflow), 25'd0);
    rst_n = 1'b1;
    tick();
    chk("blen_after_rst", 25'(blen), 25'd256);
    chk("req_after_rst", 25'(req), 25'd0);

    // First burst: wrbank 01 -> rdbank 00
    wrbank = 2'b01;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("req_fill", 25'(req), 25'd0);
    tick();
    chk("req_2clk", 25'(req), 25'd1);
    chk("raddr_first", raddr, 25'h0000000);
    valid = 1'b1;
    tick();
    chk("req_drop_on_grant", 25'(req), 25'd0);
    for (int i = 0; i < 63; i++) tick();
    chk("req_low_in_burst", 25'(req), 25'd0);
    valid = 1'b0;
    fifo_wr_len = 11'd800;
    tick();
    chk("raddr_after_burst", raddr, 25'h0000100);

    // FIFO too full -> no request until level drops to 768
    tick();
    tick();
    tick();
    chk("req_fifo_800", 25'(req), 25'd0);
    fifo_wr_len = 11'd768;
    tick();
    chk("req_fifo_768", 25'(req), 25'd1);

    // frame_start during BURST is an overrun and leaves addr/bank alone
    valid = 1'b1;
    tick();
    frame_start = 1'b1;
    wrbank = 2'b10;
    tick();
    frame_start = 1'b0;
    chk("overrun_pulse", 25'(overrun), 25'd1);
    chk("overrun_raddr", raddr, 25'h0000100);
    tick();
    chk("overrun_clear", 25'(overrun), 25'd0);

    // Overflow error follows fifo_full_flag during BURST
    fifo_full = 1'b1;
    tick();
    chk("ovf_1", 25'(overflow), 25'd1);
    tick();
    chk("ovf_2", 25'(overflow), 25'd1);
    tick();
    chk("ovf_3", 25'(overflow), 25'd1);
    fifo_full = 1'b0;
    tick();
    chk("ovf_clear", 25'(overflow), 25'd0);

    // Async reset mid-burst
    rst_n = 1'b0;
    #2;
    chk("arst_raddr", raddr, 25'd0);
    chk("arst_blen", 25'(blen), 25'd0);
    chk("arst_req", 25'(req), 25'd0);
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    fifo_wr_len = 11'd0;
    tick();

    // Full frame of 960 bursts from bank 11
    wrbank = 2'b00;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int b = 0; b < 960; b++) begin
      int w;
      logic [17:0] exp_addr;
      w = 0;
      while (!req && w < 8) begin
        tick();
        w++;
      end
      if (!req) begin
        chk("frame_req_timeout", 25'd0, 25'd1);
        break;
      end
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      exp_addr = (b == 959) ? 18'd0 : 18'((b + 1) * 256);
      chk("frame_raddr", raddr, {2'b11, 1'b0, 4'b0000, exp_addr});
    end
    chk("frame_finished", 25'(finished), 25'd1);
    tick();
    tick();
    chk("idle_no_req", 25'(req), 25'd0);
    chk("idle_raddr", raddr, 25'h1800000);

    // Next frame clears finished and picks up new bank
    wrbank = 2'b10;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("next_frame_finished", 25'(finished), 25'd0);
    chk("next_frame_raddr", raddr, 25'h0800000);
    chk("next_frame_overrun", 25'(overrun), 25'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
